// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 receive path: prefix byte values and
// the frame FSM state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchroniser, clock glitch filter, 11-bit frame FSM
// and mid-frame timeout. All outputs are single-cycle pulses in the decision cycle.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_CYC  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int FW = $clog2(GLITCH_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_s;
  logic                   dat_s;

  // NOTE: synchroniser and filter state reset to 1 so a reset on an idle
  // (high) bus cannot manufacture a falling edge when it is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= (clk_sync << 1) | SYNC_STAGES'(ps2_clk);
      dat_sync <= (dat_sync << 1) | SYNC_STAGES'(ps2_dat);
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  logic [FW-1:0] flt_cnt;
  logic          clk_flt;
  logic          clk_flt_q;
  logic          fedge;

  always_ff @(posedge clk) begin
    if (reset) begin
      flt_cnt   <= '0;
      clk_flt   <= 1'b1;
      clk_flt_q <= 1'b1;
    end else begin
      clk_flt_q <= clk_flt;
      if (clk_s == clk_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(GLITCH_CYC - 1)) begin
        flt_cnt <= '0;
        clk_flt <= clk_s;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fedge = clk_flt_q & ~clk_flt;

  frame_state_e  state, state_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [7:0]    shift, shift_next;
  logic          par, par_next;
  logic [TW-1:0] tmo_cnt;
  logic          timeout;

  // A falling edge in the expiry cycle keeps the frame alive.
  assign timeout = (state != IDLE) && !fedge && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      shift   <= shift_next;
      par     <= par_next;
      tmo_cnt <= (fedge || timeout || state == IDLE) ? '0 : tmo_cnt + 1'b1;
    end
  end

  // NOTE: every combinational output gets a default before any branch,
  // which keeps this block free of inferred latches.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    par_next     = par;
    data_valid   = 1'b0;
    parity_err   = 1'b0;
    frame_err    = 1'b0;
    if (timeout) begin
      state_next = IDLE;
      frame_err  = 1'b1;
    end else if (fedge) begin
      case (state)
        IDLE: begin
          if (!dat_s) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          shift_next   = {dat_s, shift[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          par_next   = dat_s;
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (!dat_s)               frame_err  = 1'b1;
          else if (!(^{shift, par})) parity_err = 1'b1;
          else                      data_valid = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign data = shift;

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receive front end: frame receiver plus E0/F0 prefix
// stripping, yielding one tagged scan code per key event.
module ps2_rx_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_CYC  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       is_extended,
  output logic       is_break,
  output logic       parity_err,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_perr;
  logic       rx_ferr;
  logic       ext_pend;
  logic       brk_pend;

  ps2_frame_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .GLITCH_CYC (GLITCH_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_frame_rx (
    .clk       (CLOCK_50),
    .reset     (reset),
    .ps2_clk   (PS2_CLK),
    .ps2_dat   (PS2_DAT),
    .data      (rx_byte),
    .data_valid(rx_valid),
    .parity_err(rx_perr),
    .frame_err (rx_ferr)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      code        <= '0;
      code_valid  <= 1'b0;
      is_extended <= 1'b0;
      is_break    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
    end else begin
      byte_valid <= rx_valid;
      parity_err <= rx_perr;
      frame_err  <= rx_ferr;
      code_valid <= 1'b0;
      if (rx_valid) begin
        byte_out <= rx_byte;
        if (rx_byte == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else if (rx_byte == PS2_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          code        <= rx_byte;
          is_extended <= ext_pend;
          is_break    <= brk_pend;
          code_valid  <= 1'b1;
          ext_pend    <= 1'b0;
          brk_pend    <= 1'b0;
        end
      end
      // A dropped frame may have been the tail of a prefixed sequence.
      if (rx_perr || rx_ferr) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Self-checking bench for ps2_rx_decoder: a PS/2 device model drives frames
// (time-scaled) and an event-level reference model predicts every output.
`timescale 1ns/1ps
module tb_ps2_rx_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int GLITCH_CYC  = 8;
  localparam int TIMEOUT_CYC = 400;
  localparam int HALF        = 40;   // PS/2 half-period in CLOCK_50 cycles (scaled)

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic [7:0] code;
  logic       code_valid;
  logic       is_extended;
  logic       is_break;
  logic       parity_err;
  logic       frame_err;

  ps2_rx_decoder #(
    .SYNC_STAGES(SYNC_STAGES),
    .GLITCH_CYC (GLITCH_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .PS2_CLK    (ps2_clk),
    .PS2_DAT    (ps2_dat),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .code       (code),
    .code_valid (code_valid),
    .is_extended(is_extended),
    .is_break   (is_break),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed pulse counts and timestamps.
  int   n_bv = 0, n_cv = 0, n_pe = 0, n_fe = 0;
  int   bv_cyc = 0, fe_cyc = 0;
  logic bv_q = 1'b0, cv_q = 1'b0, pe_q = 1'b0, fe_q = 1'b0;

  always @(negedge clk) begin
    if (byte_valid) begin n_bv++; bv_cyc = cyc; check("bv_width", 32'(bv_q), 0); end
    if (code_valid) begin n_cv++; check("cv_width", 32'(cv_q), 0); end
    if (parity_err) begin n_pe++; check("pe_width", 32'(pe_q), 0); end
    if (frame_err)  begin n_fe++; fe_cyc = cyc; check("fe_width", 32'(fe_q), 0); end
    bv_q = byte_valid;
    cv_q = code_valid;
    pe_q = parity_err;
    fe_q = frame_err;
  end

  // Reference model: expected cumulative pulse counts and held output values.
  int         e_bv = 0, e_cv = 0, e_pe = 0, e_fe = 0;
  logic [7:0] e_byte = 8'h00, e_code = 8'h00;
  bit         e_ext = 0, e_brk = 0, m_ext = 0, m_brk = 0;

  task automatic model_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
    if (!stop_ok) begin
      e_fe++; m_ext = 0; m_brk = 0;
    end else if (!par_ok) begin
      e_pe++; m_ext = 0; m_brk = 0;
    end else begin
      e_bv++;
      e_byte = b;
      if (b == 8'hE0)      m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        e_cv++;
        e_code = b; e_ext = m_ext; e_brk = m_brk;
        m_ext = 0; m_brk = 0;
      end
    end
  endtask

  task automatic model_reset();
    e_byte = 8'h00; e_code = 8'h00; e_ext = 0; e_brk = 0; m_ext = 0; m_brk = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int fall_cyc = 0;

  // Device model: data changes mid clock-high, host samples on clock fall.
  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok,
                            input int glitch_at, input int n_fall);
    logic [10:0] bits;
    logic        par_bit;
    par_bit = par_ok ? ~(^b) : (^b);
    bits    = {stop_ok, par_bit, b, 1'b0};
    for (int i = 0; i < n_fall; i++) begin
      ps2_dat = bits[i];
      wait_cyc(HALF / 2);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
      if (i == glitch_at) begin
        wait_cyc(15);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(HALF / 2 - 18);
      end else begin
        wait_cyc(HALF / 2);
      end
    end
    ps2_dat = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic check_state(input string tag);
    check({tag, ":bv_cnt"}, 32'(n_bv), 32'(e_bv));
    check({tag, ":cv_cnt"}, 32'(n_cv), 32'(e_cv));
    check({tag, ":pe_cnt"}, 32'(n_pe), 32'(e_pe));
    check({tag, ":fe_cnt"}, 32'(n_fe), 32'(e_fe));
    check({tag, ":byte"},   32'(byte_out), 32'(e_byte));
    check({tag, ":code"},   32'(code), 32'(e_code));
    check({tag, ":ext"},    32'(is_extended), 32'(e_ext));
    check({tag, ":brk"},    32'(is_break), 32'(e_brk));
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input bit par_ok,
                          input bit stop_ok, input int glitch_at);
    send_frame(b, par_ok, stop_ok, glitch_at, 11);
    model_frame(b, par_ok, stop_ok);
    check_state(tag);
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within 200000 cycles");
    $fatal(1, "watchdog expired");
  end

  int lat;
  int fe_before;

  initial begin
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    reset   = 1'b1;
    wait_cyc(5);
    check("reset_outputs",
          32'({byte_out, byte_valid, code, code_valid, is_extended, is_break, parity_err, frame_err}), 0);
    reset = 1'b0;
    wait_cyc(20);

    // Plain make code; measure pin-fall to byte_valid latency.
    do_frame("t1_1C", 8'h1C, 1, 1, -1);
    lat = bv_cyc - fall_cyc;
    check("t1_latency_sane", 32'(lat > 0 && lat < HALF), 1);

    do_frame("t2_F0", 8'hF0, 1, 1, -1);
    do_frame("t2_1C", 8'h1C, 1, 1, -1);

    do_frame("t3_E0", 8'hE0, 1, 1, -1);
    do_frame("t3_F0", 8'hF0, 1, 1, -1);
    do_frame("t3_75", 8'h75, 1, 1, -1);
    do_frame("t3_1C", 8'h1C, 1, 1, -1);

    do_frame("t4_F0",    8'hF0, 1, 1, -1);
    do_frame("t4_badpar", 8'h1C, 0, 1, -1);
    do_frame("t4_1C",    8'h1C, 1, 1, -1);

    // Clock stalls after start + 5 data bits.
    fe_before = n_fe;
    send_frame(8'h6B, 1, 1, -1, 6);
    for (int k = 0; k < TIMEOUT_CYC + 100 && n_fe == fe_before; k++) @(negedge clk);
    wait_cyc(5);
    check("t5_timeout_seen", 32'(n_fe - fe_before), 1);
    check("t5_timeout_delay", 32'(fe_cyc - fall_cyc), 32'(lat + TIMEOUT_CYC));
    model_frame(8'h00, 1, 0);
    check_state("t5_after");
    do_frame("t5_29", 8'h29, 1, 1, -1);

    do_frame("t6_glitch", 8'h5A, 1, 1, 3);
    do_frame("t6_E0",     8'hE0, 1, 1, 6);

    // Reset mid-frame with an extended prefix pending.
    do_frame("t6_F0", 8'hF0, 1, 1, -1);
    send_frame(8'h33, 1, 1, -1, 4);
    reset = 1'b1;
    wait_cyc(3);
    check("t6_reset_outputs",
          32'({byte_out, byte_valid, code, code_valid, is_extended, is_break, parity_err, frame_err}), 0);
    reset = 1'b0;
    model_reset();
    wait_cyc(2 * HALF);
    check_state("t6_post_reset");
    do_frame("t6_1C", 8'h1C, 1, 1, -1);

    // Randomised traffic: prefixes, random bytes, occasional bad parity/stop.
    for (int i = 0; i < 25; i++) begin
      int         r;
      logic [7:0] b;
      bit         par_ok, stop_ok;
      r       = $urandom_range(0, 9);
      b       = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
      par_ok  = ($urandom_range(0, 9) != 0);
      stop_ok = ($urandom_range(0, 14) != 0);
      do_frame("rand", b, par_ok, stop_ok, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
